register_file: RTL and testbench



---
 rtl/register_file_pkg.sv | 18 +
 rtl/register_file_word.sv | 30 +++
 rtl/register_file.sv | 81 ++++++++
 tb/tb_register_file.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared constants and types for the register_file block.
// Holds the default geometry used as parameter defaults by the top level.
package register_file_pkg;

    // Default geometry: 8 words of 8 bits, addressed by 3 bits.
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 3;
    localparam int DEFAULT_NUM_REGS   = 8;

    // One stored word at the default width.
    typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

    // True when num_regs fits the address space: 1 <= num_regs <= 2**addr_width.
    function automatic bit num_regs_valid(input int num_regs, input int addr_width);
        return (num_regs >= 1) && (num_regs <= (1 << addr_width));
    endfunction

endpackage : register_file_pkg

// File: rtl/register_file_word.sv
// register_file_word: one DATA_WIDTH-bit storage word with write enable.
// Cleared asynchronously while reset_n is low; loads i_data on a rising
// clock edge when i_enable is high.
module register_file_word
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
)(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] r_data;

    // Storage word: async clear, enabled load on the rising edge.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!reset_n) begin
            r_data <= '0;
        end else if (i_enable) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule : register_file_word

// File: rtl/register_file.sv
// register_file: NUM_REGS words of DATA_WIDTH bits, one synchronous write
// port and one combinational read port sharing a single address.
// Addresses at or above NUM_REGS are unimplemented: writes there are dropped
// and reads return 0.
//
// Optional feature: define REGISTER_FILE_DBG_PORT_EN to add an independent
// combinational debug read port (dbg_address / dbg_out) with the same
// read rules as out.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS   // must satisfy 1 <= NUM_REGS <= 2**ADDR_WIDTH
)(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] in,
`ifdef REGISTER_FILE_DBG_PORT_EN
    input  logic [ADDR_WIDTH-1:0] dbg_address,
    output logic [DATA_WIDTH-1:0] dbg_out,
`endif
    output logic [DATA_WIDTH-1:0] out
);

    // Configuration sanity flag, evaluated at elaboration.
    localparam bit CFG_OK = num_regs_valid(NUM_REGS, ADDR_WIDTH);

    logic [NUM_REGS-1:0]   w_write_en;
    logic [DATA_WIDTH-1:0] w_words [NUM_REGS];

    // One-hot write-enable decoder; unimplemented addresses select no word.
    always_comb begin
        // NOTE: default first so no path leaves a bit unassigned (no latch).
        w_write_en = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (write && CFG_OK && (int'(address) == i)) begin
                w_write_en[i] = 1'b1;
            end
        end
    end

    // Storage array: one register_file_word per implemented address.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_word
        register_file_word #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_word (
            .clock    (clock),
            .reset_n  (reset_n),
            .i_enable (w_write_en[g]),
            .i_data   (in),
            .o_data   (w_words[g])
        );
    end

    // Main read mux: word at address, 0 for unimplemented addresses.
    // Reset already clears every word, so out reads 0 while reset is held.
    always_comb begin
        out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(address) == i) begin
                out = w_words[i];
            end
        end
    end

`ifdef REGISTER_FILE_DBG_PORT_EN
    // Debug read mux: independent address, same read rules as out.
    always_comb begin
        dbg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(dbg_address) == i) begin
                dbg_out = w_words[i];
            end
        end
    end
`endif

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
// Two instances share all inputs: dut8 (NUM_REGS=8) and dut6 (NUM_REGS=6),
// so unimplemented-address behaviour is observed alongside a full instance.
module tb_register_file;
    import register_file_pkg::*;

    logic       clock;
    logic       reset_n;
    logic [2:0] address;
    logic       write;
    word_t      wdata;
    word_t      out8;
    word_t      out6;

    int checks = 0;
    int errors = 0;

`ifdef REGISTER_FILE_DBG_PORT_EN
    logic [2:0] dbg_address;
    word_t      dbg_out8;
    word_t      dbg_out6;
`endif

    register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_REGS(8)) dut8 (
        .clock       (clock),
        .reset_n     (reset_n),
        .address     (address),
        .write       (write),
        .in          (wdata),
`ifdef REGISTER_FILE_DBG_PORT_EN
        .dbg_address (dbg_address),
        .dbg_out     (dbg_out8),
`endif
        .out         (out8)
    );

    register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_REGS(6)) dut6 (
        .clock       (clock),
        .reset_n     (reset_n),
        .address     (address),
        .write       (write),
        .in          (wdata),
`ifdef REGISTER_FILE_DBG_PORT_EN
        .dbg_address (dbg_address),
        .dbg_out     (dbg_out6),
`endif
        .out         (out6)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input word_t observed, input word_t expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Global time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        address = '0;
        write   = 1'b0;
        wdata   = '0;
`ifdef REGISTER_FILE_DBG_PORT_EN
        dbg_address = 3'd7;
`endif

        // 1. Reset clears storage: every address reads 0 on both instances.
        #2;
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            check($sformatf("rst8_a%0d", a), out8, 8'h00);
            check($sformatf("rst6_a%0d", a), out6, 8'h00);
        end

        // 2. Release reset, then write lowest address on the first edge after release.
        @(negedge clock);
        reset_n = 1'b1;
        address = 3'd0;
        wdata   = 8'h01;
        write   = 1'b1;
        #1;
        check("wr0_before_edge", out8, 8'h00);
        @(posedge clock);
        #1;
        write = 1'b0;
        check("wr0_after_edge8", out8, 8'h01);
        check("wr0_after_edge6", out6, 8'h01);

        // 3. Write highest address; address 0 keeps its value.
        @(negedge clock);
        address = 3'd7;
        wdata   = 8'hAB;
        write   = 1'b1;
        @(posedge clock);
        #1;
        write = 1'b0;
        check("wr7_dut8", out8, 8'hAB);
        check("wr7_dut6_unimpl", out6, 8'h00);
        address = 3'd0;
        #1;
        check("reread0_dut8", out8, 8'h01);
        check("reread0_dut6", out6, 8'h01);

        // 4. Write disabled across several edges.
        @(negedge clock);
        address = 3'd3;
        wdata   = 8'h5A;
        write   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("nowrite3", out8, 8'h00);

        // Same-cycle read of a word being written: old value until the edge.
        @(negedge clock);
        address = 3'd0;
        wdata   = 8'h99;
        write   = 1'b1;
        #1;
        check("nobypass_before", out8, 8'h01);
        @(posedge clock);
        #1;
        write = 1'b0;
        check("nobypass_after", out8, 8'h99);

        // 5. Asynchronous reset between edges, with a write attempted during reset.
        @(negedge clock);
        address = 3'd7;
        #1;
        check("pre_reset7", out8, 8'hAB);
        reset_n = 1'b0;
        #1;
        check("async_clear7", out8, 8'h00);
        wdata = 8'h77;
        write = 1'b1;
        @(posedge clock);
        #1;
        check("write_in_reset", out8, 8'h00);
        @(negedge clock);
        write   = 1'b0;
        reset_n = 1'b1;
        #1;
        check("post_reset7", out8, 8'h00);
        address = 3'd0;
        #1;
        check("post_reset0", out8, 8'h00);

        // 6a. Back-to-back writes to address 5: last value sticks.
        @(negedge clock);
        address = 3'd5;
        wdata   = 8'h11;
        write   = 1'b1;
        @(posedge clock);
        #1;
        check("b2b_first", out8, 8'h11);
        wdata = 8'h22;
        @(posedge clock);
        #1;
        write = 1'b0;
        check("b2b_last8", out8, 8'h22);
        check("b2b_last6", out6, 8'h22);

        // 6b. Unimplemented address on the 6-word instance.
        @(negedge clock);
        address = 3'd6;
        wdata   = 8'hFF;
        write   = 1'b1;
        @(posedge clock);
        #1;
        write = 1'b0;
        check("unimpl6_dut6", out6, 8'h00);
        check("impl6_dut8", out8, 8'hFF);
        address = 3'd5;
        #1;
        check("no_alias5_dut6", out6, 8'h22);
        address = 3'd3;
        #1;
        check("untouched3", out8, 8'h00);

        // Full-width data pattern stored unmodified.
        @(negedge clock);
        address = 3'd2;
        wdata   = 8'h80;
        write   = 1'b1;
        @(posedge clock);
        #1;
        write = 1'b0;
        check("msb_pattern", out8, 8'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_register_file
